// File: rtl/seq_inv_hw_if.sv
// Handshake and data bundle for the seq_inv_hw inverse-sum solver.
// master drives the request side; slave is the solver itself.
interface seq_inv_hw_if;
    logic        start;
    logic [15:0] O;
    logic [7:0]  I2;
    logic [7:0]  I3;
    logic        busy;
    logic        done;
    logic [7:0]  I1_out;
    logic        err;

    modport master (output start, O, I2, I3, input busy, done, I1_out, err);
    modport slave  (input start, O, I2, I3, output busy, done, I1_out, err);
endinterface

// File: rtl/seq_inv_hw.sv
// Recovers I1 from O = COEF1*I1 + 18*I2 + 13*I3 with a fixed 10-cycle latency:
// one subtract cycle, then an 8-cycle restoring divide by COEF1.
module seq_inv_hw #(
    parameter int unsigned COEF1 = 23
) (
    input  logic         clk,
    input  logic         reset,
    seq_inv_hw_if.slave  bus
);
    localparam logic [15:0] RMAX = 16'(COEF1 * 255);

    typedef enum logic [1:0] {IDLE, SUB, DIV, DONE} state_t;

    state_t       state, state_next;
    logic [15:0]  o_cap;
    logic [7:0]   i2_cap, i3_cap;
    logic [15:0]  rem;
    logic [7:0]   quot;
    logic [2:0]   cnt;
    logic         range_flag;
    logic [7:0]   i1_reg;
    logic         err_reg;

    logic [12:0]        p18, p13;
    logic signed [16:0] r_sub;
    logic               r_range;
    logic [15:0]        dvs;
    logic               fits;
    logic [15:0]        rem_step;
    logic [7:0]         quot_step;

    // Shift-add products; the known-operand sum never exceeds 13 bits.
    always_comb begin
        p18       = (13'(i2_cap) << 4) + (13'(i2_cap) << 1);
        p13       = (13'(i3_cap) << 3) + (13'(i3_cap) << 2) + 13'(i3_cap);
        r_sub     = $signed({1'b0, o_cap}) - $signed({4'd0, p18 + p13});
        r_range   = r_sub[16] || (r_sub[15:0] > RMAX);
        dvs       = 16'(COEF1) << cnt;
        fits      = (rem >= dvs);
        rem_step  = fits ? (rem - dvs) : rem;
        quot_step = quot;
        quot_step[cnt] = fits;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (bus.start) state_next = SUB;
            SUB:  state_next = DIV;
            DIV:  if (cnt == 3'd0) state_next = DONE;
            DONE: state_next = bus.start ? SUB : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_cap      <= '0;
            i2_cap     <= '0;
            i3_cap     <= '0;
            rem        <= '0;
            quot       <= '0;
            cnt        <= '0;
            range_flag <= 1'b0;
            i1_reg     <= '0;
            err_reg    <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        o_cap  <= bus.O;
                        i2_cap <= bus.I2;
                        i3_cap <= bus.I3;
                        quot   <= '0;
                    end
                end
                SUB: begin
                    rem        <= {3'd0, r_sub[12:0]};
                    range_flag <= r_range;
                    cnt        <= 3'd7;
                end
                DIV: begin
                    rem  <= rem_step;
                    quot <= quot_step;
                    cnt  <= cnt - 3'd1;
                    // Results land on the last divide step so they are valid in DONE.
                    if (cnt == 3'd0) begin
                        i1_reg  <= range_flag ? 8'd0 : quot_step;
                        err_reg <= range_flag || (rem_step != 16'd0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy   = (state == SUB) || (state == DIV);
    assign bus.done   = (state == DONE);
    assign bus.I1_out = i1_reg;
    assign bus.err    = err_reg;
endmodule

// File: tb/tb_seq_inv_hw.sv
// Bench for seq_inv_hw: directed vector table, handwritten timing/reset
// sequences, and random operands against an arithmetic reference model.
module tb_seq_inv_hw;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    seq_inv_hw_if bus();
    seq_inv_hw #(.COEF1(23)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [15:0] o;
        logic [7:0]  i2;
        logic [7:0]  i3;
        logic [7:0]  exp_i1;
        logic        exp_err;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic void model(input int o, input int i2, input int i3,
                                  output int e1, output int ee);
        int r;
        r = o - 18 * i2 - 13 * i3;
        if (r < 0 || r > 23 * 255) begin
            e1 = 0;
            ee = 1;
        end else begin
            e1 = r / 23;
            ee = (r % 23 != 0) ? 1 : 0;
        end
    endfunction

    // One full operation; inputs are scrambled while busy, optional start pulse mid-divide.
    task automatic do_op(input string name, input logic [15:0] o, input logic [7:0] i2,
                         input logic [7:0] i3, input int e1, input int ee, input bit mid_pulse);
        bit timing_ok;
        timing_ok = 1'b1;
        @(negedge clk);
        bus.start = 1'b1;
        bus.O = o; bus.I2 = i2; bus.I3 = i3;
        @(posedge clk);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            bus.start = (mid_pulse && k == 5) ? 1'b1 : 1'b0;
            bus.O  = 16'($urandom);
            bus.I2 = 8'($urandom);
            bus.I3 = 8'($urandom);
            if (!(bus.busy === 1'b1 && bus.done === 1'b0)) timing_ok = 1'b0;
        end
        bus.start = 1'b0;
        chk({name, "_busy9"}, 32'(timing_ok), 32'd1);
        @(negedge clk);
        chk({name, "_done"}, {30'd0, bus.done, bus.busy}, 32'd2);
        chk({name, "_i1"}, 32'(bus.I1_out), 32'(e1));
        chk({name, "_err"}, 32'(bus.err), 32'(ee));
    endtask

    vec_t vecs[8];

    initial begin
        int e1, ee;
        bit flag;
        logic [7:0] a1, a2, a3;
        logic [15:0] ro;

        vecs[0] = '{16'd359,   8'd5,   8'd3,   8'd10,  1'b0};
        vecs[1] = '{16'd13770, 8'd255, 8'd255, 8'd255, 1'b0};
        vecs[2] = '{16'd360,   8'd5,   8'd3,   8'd10,  1'b1};
        vecs[3] = '{16'd100,   8'd5,   8'd3,   8'd0,   1'b1};
        vecs[4] = '{16'd65535, 8'd0,   8'd0,   8'd0,   1'b1};
        vecs[5] = '{16'd5865,  8'd0,   8'd0,   8'd255, 1'b0};
        vecs[6] = '{16'd5866,  8'd0,   8'd0,   8'd0,   1'b1};
        vecs[7] = '{16'd0,     8'd0,   8'd0,   8'd0,   1'b0};

        reset = 1'b1;
        bus.start = 1'b0; bus.O = '0; bus.I2 = '0; bus.I3 = '0;
        repeat (3) @(negedge clk);
        chk("rst_outputs", {28'd0, bus.busy, bus.done, bus.err, |bus.I1_out}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++)
            do_op($sformatf("vec%0d", i), vecs[i].o, vecs[i].i2, vecs[i].i3,
                  int'(vecs[i].exp_i1), int'(vecs[i].exp_err), 1'b0);

        // Held result persists through IDLE.
        @(negedge clk);
        chk("hold_idle", {23'd0, bus.done, bus.I1_out}, 32'd0);

        // Start pulsed mid-divide must be ignored.
        do_op("mid_start", 16'd359, 8'd5, 8'd3, 10, 0, 1'b1);

        // Start held high through DONE: back-to-back results 10 cycles apart.
        @(negedge clk);
        bus.start = 1'b1; bus.O = 16'd359; bus.I2 = 8'd5; bus.I3 = 8'd3;
        @(posedge clk);
        flag = 1'b1;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            if (cyc == 10) begin
                chk("b2b_done1", {31'd0, bus.done}, 32'd1);
                chk("b2b_i1_1", 32'(bus.I1_out), 32'd10);
                bus.O = 16'd13770; bus.I2 = 8'd255; bus.I3 = 8'd255;
            end else if (cyc == 20) begin
                chk("b2b_done2", {31'd0, bus.done}, 32'd1);
                chk("b2b_i1_2", 32'(bus.I1_out), 32'd255);
                chk("b2b_err2", 32'(bus.err), 32'd0);
                bus.start = 1'b0;
            end else if (!(bus.busy === 1'b1 && bus.done === 1'b0)) begin
                flag = 1'b0;
            end
        end
        chk("b2b_busy", 32'(flag), 32'd1);

        // Reset in the 4th divide cycle aborts immediately with no done pulse.
        @(negedge clk);
        bus.start = 1'b1; bus.O = 16'd1000; bus.I2 = 8'd5; bus.I3 = 8'd3;
        @(posedge clk);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        reset = 1'b1;
        #1;
        chk("rst_mid_outputs", {23'd0, bus.busy, bus.done, bus.err, 6'd0} | 32'(bus.I1_out), 32'd0);
        flag = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) flag = 1'b1;
        end
        chk("rst_no_done", 32'(flag), 32'd0);
        do_op("after_rst", 16'd1000, 8'd5, 8'd3, 37, 1, 1'b0);

        // Random forward-model round trips: always exact.
        for (int n = 0; n < 150; n++) begin
            a1 = 8'($urandom); a2 = 8'($urandom); a3 = 8'($urandom);
            ro = 16'(23 * int'(a1) + 18 * int'(a2) + 13 * int'(a3));
            do_op("fwd", ro, a2, a3, int'(a1), 0, 1'b0);
        end
        do_op("fwd_max", 16'(23 * 255 + 18 * 255 + 13 * 255), 8'd255, 8'd255, 255, 0, 1'b0);
        do_op("fwd_min", 16'd0, 8'd0, 8'd0, 0, 0, 1'b0);

        // Random arbitrary words against the arithmetic model.
        for (int n = 0; n < 60; n++) begin
            ro = (n % 2 == 0) ? 16'($urandom_range(0, 14000)) : 16'($urandom);
            a2 = 8'($urandom); a3 = 8'($urandom);
            model(int'(ro), int'(a2), int'(a3), e1, ee);
            do_op("rand", ro, a2, a3, e1, ee, 1'b0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
